rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive cycles one grant SHALL be held (legal range 1..15).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  arbitration enable; when low, no new grant SHALL be issued.
REQ-005 req  input  8  request vector; bit i high = requester i wants the resource.
REQ-006 gnt  output  8  one-hot grant; all-zero when no grant is active.
REQ-007 gnt_idx  output  3  binary index of the granted requester; valid only when gnt_valid is high.
REQ-008 gnt_valid  output  1  high while a grant is active.

Function
REQ-009 FSM states: IDLE (no grant), GRANT (one requester owns the resource).
- REQ-010 IDLE -> GRANT when en=1 and req!=0, sampled at edge N; gnt/gnt_idx/gnt_valid SHALL be asserted from edge N+1 (one-cycle latency).
- REQ-011 Winner = first requester i with req[i]=1, searching ptr, ptr+1, ..., ptr+7 (mod 8); ptr is a 3-bit rotating priority pointer.
- REQ-012 IDLE with en=0 or req=0 -> remain IDLE, outputs zero.
- REQ-013 In GRANT, hold_cnt SHALL count cycles of the current grant, starting at 1 in the first grant cycle.
- REQ-014 GRANT -> IDLE (release) at an edge where any of: req[gnt_idx]=0, hold_cnt=MAX_HOLD, en=0.
- REQ-015 On release, ptr SHALL become gnt_idx+1 (3-bit wrap, 7 -> 0), and gnt SHALL be zero for exactly one cycle before any new grant.
- REQ-016 gnt SHALL equal the one-hot decode of gnt_idx when gnt_valid=1, else 8'h00; never more than one bit set.
- REQ-017 gnt_idx SHALL hold its last value while gnt_valid=0; it SHALL be ignored by consumers.
- REQ-018 Changes to req bits other than req[gnt_idx] during GRANT SHALL NOT affect the current grant.
- REQ-019 Simultaneous release and new requests: release takes precedence; new request is arbitrated in the following IDLE cycle.
- REQ-020 MAX_HOLD=1: every grant SHALL last exactly one cycle, followed by one idle cycle.

Reset
REQ-021 rst=1 at an edge SHALL force state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, overriding all other inputs.
REQ-022 rst asserted mid-grant SHALL drop gnt on the next edge; first grant after rst deasserts SHALL use ptr=0.

Structure
REQ-023 FSM state enum, NUM_REQ=8, and IDX_W=3 SHALL live in shared package arb_pkg.
REQ-024 The index-to-one-hot conversion SHALL be a separate combinational sub-module onehot_dec8 (3-bit idx, enable, 8-bit out), instantiated once with enable=gnt_valid.
REQ-025 Priority search SHALL be purely combinational from ptr and req; no other clocked logic.

Verification
REQ-026 rst for 2 cycles, then req=8'h00, en=1 for 5 cycles -> gnt=8'h00, gnt_valid=0 throughout.
REQ-027 After reset, req=8'h81 held, en=1 -> gnt=8'h01 for 4 cycles, 1 idle cycle, gnt=8'h80 for 4 cycles, 1 idle cycle, gnt=8'h01.
REQ-028 req=8'hFF held, MAX_HOLD=4 -> grants rotate idx 0,1,...,7,0, each 4 cycles, separated by 1 idle cycle; gnt always one-hot or zero.
REQ-029 Grant on idx 2, req[2] dropped after 2 cycles while req[5]=1 -> gnt=8'h00 next cycle, then gnt=8'h20.
REQ-030 Grant on idx 3, en driven low -> gnt=8'h00 next edge; stays zero while en=0 despite req=8'hFF; after en=1, next grant is idx 4.
REQ-031 rst pulsed during grant on idx 6 with req=8'hFF -> outputs zero next edge; first grant after rst is idx 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/onehot_dec8.sv
// Binary index to one-hot decoder; output is all-zero when disabled.
module onehot_dec8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_onehot
);
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_idx == IDX_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with bounded grant hold time and a
// mandatory idle cycle between consecutive grants.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [3:0]       r_hold_cnt;
    logic [3:0]       w_hold_next;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_idx_next;

    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_cand;

    // Search starts at the pointer and wraps, so the requester after the
    // last owner has top priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = r_ptr + IDX_W'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_hold_next  = r_hold_cnt;
        w_idx_next   = r_gnt_idx;
        case (r_state)
            ST_IDLE: begin
                if (en && w_found) begin
                    w_state_next = ST_GRANT;
                    w_idx_next   = w_win;
                    w_hold_next  = 4'd1;
                end
            end
            ST_GRANT: begin
                // Release always wins over pending requests; the next
                // winner is chosen from the idle cycle that follows.
                if (!req[r_gnt_idx] || (r_hold_cnt == HOLD_MAX) || !en) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = r_gnt_idx + IDX_W'(1);
                    w_hold_next  = 4'd0;
                end else begin
                    w_hold_next  = r_hold_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt_idx  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_hold_next;
            r_gnt_idx  <= w_idx_next;
        end
    end

    assign gnt_valid = (r_state == ST_GRANT);
    assign gnt_idx   = r_gnt_idx;

    onehot_dec8 u_dec (
        .i_idx    (r_gnt_idx),
        .i_en     (gnt_valid),
        .o_onehot (gnt)
    );
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed, table-driven bench for rr_arbiter8 (MAX_HOLD=4 and MAX_HOLD=1).
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    logic [7:0] req1 = 8'h00;
    logic [7:0] gnt1;
    logic [2:0] gnt_idx1;
    logic       gnt_valid1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    rr_arbiter8 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req1),
        .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] exp_gnt;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic       chk_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] rq,
                       input logic [7:0] g, input logic v, input logic [2:0] ix,
                       input logic ci);
        vec_t t;
        t.rst = r; t.en = e; t.req = rq;
        t.exp_gnt = g; t.exp_valid = v; t.exp_idx = ix; t.chk_idx = ci;
        vecs.push_back(t);
    endtask

    task automatic add_n(input int n, input logic e, input logic [7:0] rq,
                         input logic [7:0] g, input logic v, input logic [2:0] ix);
        for (int i = 0; i < n; i++) add(1'b0, e, rq, g, v, ix, v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] ag, input logic av,
                         input logic [2:0] ai, input logic [7:0] eg, input logic ev,
                         input logic [2:0] ei, input logic ci);
        n_vec++;
        if (ag !== eg || av !== ev || (ci && ai !== ei)) begin
            n_err++;
            $display("FAIL %s: got gnt=%02h valid=%0b idx=%0d, want gnt=%02h valid=%0b idx=%0d",
                     name, ag, av, ai, eg, ev, ei);
        end else begin
            $display("vec %0d %s: gnt=%02h valid=%0b idx=%0d ok", n_vec, name, ag, av, ai);
        end
    endtask

    initial begin
        // reset, then no requests
        add(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
        add_n(5, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0);
        // two requesters at the wrap boundary
        add_n(4, 1'b1, 8'h81, 8'h01, 1'b1, 3'd0);
        add_n(1, 1'b1, 8'h81, 8'h00, 1'b0, 3'd0);
        add_n(4, 1'b1, 8'h81, 8'h80, 1'b1, 3'd7);
        add_n(1, 1'b1, 8'h81, 8'h00, 1'b0, 3'd0);
        add_n(1, 1'b1, 8'h81, 8'h01, 1'b1, 3'd0);
        // reset mid-grant clears outputs and idx
        add(1'b1, 1'b1, 8'h81, 8'h00, 1'b0, 3'd0, 1'b1);
        // idx 2 drops its request, idx 5 follows after one idle cycle
        add_n(2, 1'b1, 8'h24, 8'h04, 1'b1, 3'd2);
        add_n(1, 1'b1, 8'h20, 8'h00, 1'b0, 3'd0);
        add_n(2, 1'b1, 8'h20, 8'h20, 1'b1, 3'd5);
        add_n(1, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0);
        // ptr=6 now: idx 3 wins, then en low releases and blocks
        add_n(1, 1'b1, 8'h08, 8'h08, 1'b1, 3'd3);
        add_n(3, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0);
        add_n(4, 1'b1, 8'hFF, 8'h10, 1'b1, 3'd4);
        add_n(1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0);
        add_n(4, 1'b1, 8'hFF, 8'h20, 1'b1, 3'd5);
        add_n(1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0);
        add_n(2, 1'b1, 8'hFF, 8'h40, 1'b1, 3'd6);
        // reset during idx 6 grant; restart from ptr 0
        add(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b1);
        add_n(2, 1'b1, 8'hFF, 8'h01, 1'b1, 3'd0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            req = vecs[i].req;
            step();
            check("table", gnt, gnt_valid, gnt_idx,
                  vecs[i].exp_gnt, vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].chk_idx);
        end

        // full rotation with all requesters active
        rst = 1'b1; en = 1'b1; req = 8'hFF;
        step(); step();
        rst = 1'b0;
        for (int g = 0; g < 9; g++) begin
            logic [2:0] ix;
            logic [7:0] oh;
            ix = 3'(g % 8);
            oh = 8'h01 << ix;
            for (int c = 0; c < 4; c++) begin
                step();
                check("rotate_grant", gnt, gnt_valid, gnt_idx, oh, 1'b1, ix, 1'b1);
            end
            step();
            check("rotate_idle", gnt, gnt_valid, gnt_idx, 8'h00, 1'b0, 3'd0, 1'b0);
        end

        // MAX_HOLD=1: one-cycle grants separated by one idle cycle
        rst = 1'b1; req = 8'h00; req1 = 8'h00;
        step();
        rst = 1'b0; req1 = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            logic [2:0] ix;
            logic [7:0] oh;
            ix = 3'(k / 2);
            oh = 8'h01 << ix;
            step();
            if (k % 2 == 0)
                check("hold1_grant", gnt1, gnt_valid1, gnt_idx1, oh, 1'b1, ix, 1'b1);
            else
                check("hold1_idle", gnt1, gnt_valid1, gnt_idx1, 8'h00, 1'b0, 3'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
